// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per-channel 2-flop synchronizer, stability counter,
// registered debounced level and one-cycle rise/fall pulses.
module multi_debouncer #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEB_CYCLES = 3_333_334,
  parameter int unsigned CNT_W      = 22
) (
  input  logic            clk_50M,
  input  logic            reset,
  input  logic [N_CH-1:0] D,
  output logic [N_CH-1:0] D_deb,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  logic [N_CH-1:0]            s1_q, s2_q;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]            deb_q, deb_d;
  logic [N_CH-1:0]            rise_q, rise_d;
  logic [N_CH-1:0]            fall_q, fall_d;

  // A disagreeing sample advances the count; agreement discards any partial count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      s1_q   <= D;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign D_deb   = deb_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = |(rise_q | fall_q);

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer with N_CH=4, DEB_CYCLES=4.
module tb_multi_debouncer;

  logic       clk_50M = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] D       = 4'b0000;
  logic [3:0] D_deb, rise, fall;
  logic       changed;

  int checks   = 0;
  int failures = 0;
  int rise_tot [4];
  int fall_tot [4];
  int chg_tot  = 0;
  int base_r, base_f, base_c;

  multi_debouncer #(
    .N_CH      (4),
    .DEB_CYCLES(4),
    .CNT_W     (3)
  ) dut (
    .clk_50M(clk_50M),
    .reset  (reset),
    .D      (D),
    .D_deb  (D_deb),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 time unit later.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(posedge clk_50M);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d_after);
    reset = 1'b1;
    tick(2);
    D = d_after;
    tick(3);
    reset = 1'b0;
  endtask

  // Pulse bookkeeping and per-cycle invariants, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_tot[i] = 0;
      fall_tot[i] = 0;
    end
  end

  always @(negedge clk_50M) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        rise_tot[i] += int'(rise[i]);
        fall_tot[i] += int'(fall[i]);
      end
      chg_tot += int'(changed);
      check_eq("rise_fall_excl", 32'(rise & fall), 32'd0);
      check_eq("changed_or", 32'(changed), 32'(|(rise | fall)));
    end
  end

  initial begin
    // Reset holds everything at 0 even with D active and clock running.
    reset = 1'b1;
    D = 4'b1010;
    tick(3);
    check_eq("rst_deb", 32'(D_deb), 32'd0);
    check_eq("rst_rise", 32'(rise), 32'd0);
    check_eq("rst_fall", 32'(fall), 32'd0);
    check_eq("rst_changed", 32'(changed), 32'd0);
    do_reset(4'b0000);
    tick(4);

    // Single clean step on channel 0.
    D = 4'b0001;
    tick(5);
    check_eq("t1_e5_deb", 32'(D_deb), 32'd0);
    tick(1);
    check_eq("t1_e6_deb", 32'(D_deb), 32'h1);
    check_eq("t1_e6_rise", 32'(rise), 32'h1);
    check_eq("t1_e6_chg", 32'(changed), 32'd1);
    tick(1);
    check_eq("t1_e7_rise", 32'(rise), 32'd0);
    check_eq("t1_e7_deb", 32'(D_deb), 32'h1);

    // Channel 1 bounces 3 high / 1 low twice, then holds high.
    base_r = rise_tot[1];
    D[1] = 1'b1; tick(3);
    D[1] = 1'b0; tick(1);
    check_eq("t2_bounce1_deb", 32'(D_deb[1]), 32'd0);
    D[1] = 1'b1; tick(3);
    D[1] = 1'b0; tick(1);
    check_eq("t2_bounce2_deb", 32'(D_deb[1]), 32'd0);
    D[1] = 1'b1;
    tick(5);
    check_eq("t2_e5_deb", 32'(D_deb[1]), 32'd0);
    tick(1);
    check_eq("t2_e6_deb", 32'(D_deb), 32'h3);
    check_eq("t2_e6_rise", 32'(rise), 32'h2);
    tick(3);
    check_eq("t2_rise_count", 32'(rise_tot[1] - base_r), 32'd1);

    // All channels step together.
    do_reset(4'b0000);
    tick(4);
    D = 4'b1111;
    tick(5);
    check_eq("t3_e5_deb", 32'(D_deb), 32'd0);
    tick(1);
    check_eq("t3_e6_deb", 32'(D_deb), 32'hf);
    check_eq("t3_e6_rise", 32'(rise), 32'hf);
    check_eq("t3_e6_chg", 32'(changed), 32'd1);
    tick(1);
    check_eq("t3_e7_rise", 32'(rise), 32'd0);
    check_eq("t3_e7_chg", 32'(changed), 32'd0);

    // Channel 2 falls.
    base_r = rise_tot[2];
    base_f = fall_tot[2];
    D = 4'b1011;
    tick(5);
    check_eq("t4_e5_fall", 32'(fall), 32'd0);
    check_eq("t4_e5_deb", 32'(D_deb), 32'hf);
    tick(1);
    check_eq("t4_e6_fall", 32'(fall), 32'h4);
    check_eq("t4_e6_deb", 32'(D_deb), 32'hb);
    check_eq("t4_e6_rise", 32'(rise), 32'd0);
    tick(2);
    check_eq("t4_rise2_count", 32'(rise_tot[2] - base_r), 32'd0);
    check_eq("t4_fall2_count", 32'(fall_tot[2] - base_f), 32'd1);

    // Asynchronous reset mid-count on channel 3 while channel 0 is debounced high.
    do_reset(4'b0001);
    tick(6);
    check_eq("t5_pre_deb", 32'(D_deb), 32'h1);
    D = 4'b1001;
    tick(2);
    #1 reset = 1'b1;
    #1 check_eq("t5_async_deb", 32'(D_deb), 32'd0);
    #2 reset = 1'b0;
    tick(5);
    check_eq("t5_e5_deb", 32'(D_deb), 32'd0);
    tick(1);
    check_eq("t5_e6_deb", 32'(D_deb), 32'h9);
    check_eq("t5_e6_rise", 32'(rise), 32'h9);

    // Short glitch on channel 0 is filtered.
    do_reset(4'b0000);
    tick(4);
    base_r = rise_tot[0];
    base_c = chg_tot;
    D[0] = 1'b1; tick(3);
    D[0] = 1'b0; tick(10);
    check_eq("t6_deb", 32'(D_deb), 32'd0);
    check_eq("t6_rise_count", 32'(rise_tot[0] - base_r), 32'd0);
    check_eq("t6_chg_count", 32'(chg_tot - base_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
